// File: rtl/shader_trace_pkg.sv
// Shared encodings for the shader trace buffer: FSM states, stamp width, capture modes.
package shader_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  localparam int   STAMP_W   = 16;
  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

endpackage

// File: rtl/trace_ring_mem.sv
// DEPTH-entry circular store with registered head output, occupancy count and
// optional overwrite-oldest when a write arrives while full.
module trace_ring_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_pop,
  input  logic                     wrap,
  output logic                     rd_valid,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          push, pop;

  always_comb begin
    full      = (count_q == FULL_CNT);
    pop       = rd_pop && (count_q != '0);
    push      = wr_en && (!full || pop || wrap);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_data_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      // Overwrite on full drops the oldest entry, so the head moves too.
      if (pop || (push && full)) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop && !full) count_d = count_q + 1'b1;
      else if (pop && !push)     count_d = count_q - 1'b1;
      // Bypass so a write landing on the new head is visible one cycle later.
      if (push && (wr_ptr_q == rd_ptr_d)) rd_data_d = wr_data;
      else                                rd_data_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_data_q;
  assign count    = count_q;

endmodule

// File: rtl/shader_trace_buffer.sv
// PC-triggered retire trace capture into a circular buffer with stop/wrap modes.
// Define TRACE_TIMESTAMP_EN to build the per-entry 16-bit cycle stamp.
module shader_trace_buffer
  import shader_trace_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic                       wrap_mode,
  input  logic [PC_W-1:0]            trig_pc,
  input  logic                       retire,
  input  logic [PC_W-1:0]            pc,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [PC_W-1:0]            rd_pc,
  output logic [NUM_REGS*DATA_W-1:0] rd_regs,
  output logic [15:0]                rd_stamp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [1:0]                 state
);
  localparam int RW    = NUM_REGS * DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = PC_W + RW + STAMP_W;
`else
  localparam int EW = PC_W + RW;
`endif

  trace_state_e   state_q, state_d;
  logic           wrap_q, wrap_d;
  logic           overflow_q, overflow_d;
  logic           wr_en, clr, pop, full, will_fill;
  logic [EW-1:0]  wr_data, rd_data;

  always_comb begin
    state_d    = state_q;
    wrap_d     = wrap_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    clr        = 1'b0;
    pop        = rd_valid && rd_ready;
    will_fill  = (count == CNT_W'(DEPTH - 1)) && !pop;
    if (arm) begin
      state_d    = ST_ARMED;
      clr        = 1'b1;
      wrap_d     = wrap_mode;
      overflow_d = 1'b0;
    end else if (disarm) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_ARMED: if (retire && (pc == trig_pc)) begin
          wr_en   = 1'b1;
          state_d = ST_CAPTURE;
        end
        ST_CAPTURE: if (retire) begin
          wr_en = 1'b1;
          if (wrap_q == MODE_STOP && will_fill) state_d = ST_DONE;
        end
        default: ;
      endcase
      if (wr_en && full && !pop && wrap_q == MODE_WRAP) overflow_d = 1'b1;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [STAMP_W-1:0] stamp_q, stamp_d;

  // Stamp counts cycles since arm; an entry records the value reached at its write edge.
  always_comb begin
    stamp_d = stamp_q;
    if (arm) stamp_d = '0;
    else if ((state_q == ST_ARMED || state_q == ST_CAPTURE) && stamp_q != '1)
      stamp_d = stamp_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp_q <= '0;
    else        stamp_q <= stamp_d;
  end

  assign wr_data  = {pc, regs_flat, stamp_d};
  assign rd_stamp = rd_data[STAMP_W-1:0];
`else
  assign wr_data  = {pc, regs_flat};
  assign rd_stamp = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wrap_q     <= MODE_STOP;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
    end
  end

  trace_ring_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_pop   (pop),
    .wrap     (wrap_q),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full)
  );

  assign rd_pc    = rd_data[EW-1 -: PC_W];
  assign rd_regs  = rd_data[EW-PC_W-1 -: RW];
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_shader_trace_buffer.sv
// Directed self-checking bench for shader_trace_buffer (default parameters).
module tb_shader_trace_buffer;
  logic         clk = 1'b0;
  logic         rst_n, arm, disarm, wrap_mode, retire, rd_ready;
  logic [7:0]   trig_pc, pc;
  logic [127:0] regs_flat;
  logic         rd_valid, overflow;
  logic [7:0]   rd_pc;
  logic [127:0] rd_regs;
  logic [15:0]  rd_stamp;
  logic [4:0]   count;
  logic [1:0]   state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  shader_trace_buffer dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .wrap_mode(wrap_mode),
    .trig_pc(trig_pc), .retire(retire), .pc(pc), .regs_flat(regs_flat),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_regs(rd_regs),
    .rd_stamp(rd_stamp), .count(count), .overflow(overflow), .state(state)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  // Register snapshot pattern tied to the retiring PC.
  function automatic logic [127:0] mkregs(input logic [7:0] p);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {8'(i + 1), 8'hC0, 8'h00, p};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic wm, input logic [7:0] tp);
    wrap_mode = wm; trig_pc = tp; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_retire(input logic [7:0] p, input logic rdy);
    pc = p; regs_flat = mkregs(p); retire = 1'b1; rd_ready = rdy;
    tick();
    retire = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic drain_check(input string tag, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_rd_pc%0d", tag, k), rd_pc, first + 8'(k));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    check({tag, "_empty_count"}, count, 0);
    check({tag, "_empty_valid"}, rd_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; wrap_mode = 1'b0; retire = 1'b0;
    rd_ready = 1'b0; trig_pc = '0; pc = '0; regs_flat = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_pc", rd_pc, 0);

    // Trigger on 03: earlier PCs ignored; stamp = cycles since arm.
    do_arm(1'b0, 8'h03);
    check("arm_state", state, 1);
    do_retire(8'h01, 1'b0);
    do_retire(8'h02, 1'b0);
    check("pretrig_count", count, 0);
    do_retire(8'h03, 1'b0);
    check("trig_state", state, 2);
    check("trig_valid", rd_valid, 1);
    check("trig_rd_pc", rd_pc, 8'h03);
    check("trig_rd_regs", rd_regs, mkregs(8'h03));
`ifdef TRACE_TIMESTAMP_EN
    check("trig_stamp", rd_stamp, 3);
`else
    check("trig_stamp", rd_stamp, 0);
`endif
    do_retire(8'h04, 1'b0);
    check("trig_count2", count, 2);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("pop_rd_pc", rd_pc, 8'h04);
    check("pop_rd_regs", rd_regs, mkregs(8'h04));
`ifdef TRACE_TIMESTAMP_EN
    check("pop_stamp", rd_stamp, 4);
`else
    check("pop_stamp", rd_stamp, 0);
`endif
    rd_ready = 1'b1; tick(); tick(); rd_ready = 1'b0;
    check("empty_pop_count", count, 0);
    check("empty_pop_valid", rd_valid, 0);

    // Asynchronous reset mid-capture with five entries held.
    for (int k = 0; k < 5; k++) do_retire(8'h10 + 8'(k), 1'b0);
    check("prerst_count", count, 5);
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_count", count, 0);
    check("arst_valid", rd_valid, 0);
    check("arst_overflow", overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Stop mode: 20 retires, only the first 16 kept.
    do_arm(1'b0, 8'h20);
    for (int k = 0; k < 20; k++) do_retire(8'h20 + 8'(k), 1'b0);
    check("stop_count", count, 16);
    check("stop_state", state, 3);
    check("stop_overflow", overflow, 0);
    drain_check("stop", 8'h20, 16);

    // Wrap mode: 20 retires, oldest four overwritten.
    do_arm(1'b1, 8'h40);
    for (int k = 0; k < 20; k++) do_retire(8'h40 + 8'(k), 1'b0);
    check("wrap_count", count, 16);
    check("wrap_overflow", overflow, 1);
    check("wrap_state", state, 2);
    drain_check("wrap", 8'h44, 16);

    // Wrap mode full, retire with simultaneous pop.
    do_arm(1'b1, 8'h60);
    check("rearm_overflow", overflow, 0);
    for (int k = 0; k < 16; k++) do_retire(8'h60 + 8'(k), 1'b0);
    check("full_count", count, 16);
    do_retire(8'h70, 1'b1);
    check("wrpop_count", count, 16);
    check("wrpop_overflow", overflow, 0);
    check("wrpop_rd_pc", rd_pc, 8'h61);

    // Disarm stops capture.
    disarm = 1'b1; tick(); disarm = 1'b0;
    check("disarm_state", state, 3);
    do_retire(8'h71, 1'b0);
    check("disarm_count", count, 16);
    check("disarm_overflow", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
